// File: rtl/reg_bank_if.sv
// Operand-fetch bus between decode and the register bank: write port, reserve port,
// dual read request and the registered read response with scoreboard state.
interface reg_bank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
);
    localparam int NREG = 1 << ADDR_W;

    logic              opwrite;
    logic [ADDR_W-1:0] reg_write;
    logic [DATA_W-1:0] data;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] src_1;
    logic [ADDR_W-1:0] src_2;
    logic [DATA_W-1:0] data_src_1;
    logic [DATA_W-1:0] data_src_2;
    logic              rd_valid;
    logic              rd_stall;
    logic [NREG-1:0]   pending;

    modport master (
        output opwrite, reg_write, data, rsv_en, rsv_addr, rd_en, src_1, src_2,
        input  data_src_1, data_src_2, rd_valid, rd_stall, pending
    );

    modport slave (
        input  opwrite, reg_write, data, rsv_en, rsv_addr, rd_en, src_1, src_2,
        output data_src_1, data_src_2, rd_valid, rd_stall, pending
    );
endinterface

// File: rtl/reg_bank_param.sv
// Parametrised register bank with two registered read ports, write-to-read bypass,
// optional hard-wired zero register and a pending scoreboard that stalls reads.
//
// state | meaning
// IDLE  | accepting read requests from decode
// HOLD  | latched request waiting for its pending source registers to be written
module reg_bank_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    reg_bank_if.slave  bus
);
    localparam int NREG = 1 << ADDR_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem [NREG];
    logic [NREG-1:0]   pend_q, pend_d;
    logic [ADDR_W-1:0] hold_1_q, hold_2_q;
    logic [DATA_W-1:0] data_1_q, data_2_q;
    logic              valid_q, stall_q;

    logic [ADDR_W-1:0] addr_1, addr_2;
    logic              fwd_1, fwd_2;
    logic              ready_1, ready_2;
    logic [DATA_W-1:0] rdata_1, rdata_2;
    logic              load, latch;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    always_comb begin
        addr_1  = (state_q == HOLD) ? hold_1_q : bus.src_1;
        addr_2  = (state_q == HOLD) ? hold_2_q : bus.src_2;
        fwd_1   = (BYPASS != 0) && bus.opwrite && (bus.reg_write == addr_1);
        fwd_2   = (BYPASS != 0) && bus.opwrite && (bus.reg_write == addr_2);
        ready_1 = !pend_q[addr_1] || fwd_1;
        ready_2 = !pend_q[addr_2] || fwd_2;
        // Zero register wins over a forwarded write to address 0.
        rdata_1 = is_zero(addr_1) ? '0 : (fwd_1 ? bus.data : mem[addr_1]);
        rdata_2 = is_zero(addr_2) ? '0 : (fwd_2 ? bus.data : mem[addr_2]);
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rd_en) begin
                    if (ready_1 && ready_2) begin
                        load = 1'b1;
                    end else begin
                        latch   = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (ready_1 && ready_2) begin
                    load    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            hold_1_q <= '0;
            hold_2_q <= '0;
            data_1_q <= '0;
            data_2_q <= '0;
            valid_q  <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                hold_1_q <= bus.src_1;
                hold_2_q <= bus.src_2;
            end
            if (load) begin
                data_1_q <= rdata_1;
                data_2_q <= rdata_2;
            end
            valid_q <= load;
            stall_q <= (state_d == HOLD);
        end
    end

    // Reserve is applied after the write clear so a same-edge reserve keeps the bit set.
    always_comb begin
        pend_d = pend_q;
        if (bus.opwrite) pend_d[bus.reg_write] = 1'b0;
        if (bus.rsv_en)  pend_d[bus.rsv_addr]  = 1'b1;
        if (ZERO_REG != 0) pend_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (bus.opwrite && !is_zero(bus.reg_write)) begin
            mem[bus.reg_write] <= bus.data;
        end
    end

    assign bus.data_src_1 = data_1_q;
    assign bus.data_src_2 = data_2_q;
    assign bus.rd_valid   = valid_q;
    assign bus.rd_stall   = stall_q;
    assign bus.pending    = pend_q;
endmodule
